// File: rtl/dir_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : dir_input_conditioner
// Description : Direction-button front end for the dungeon game. Each of the
//               four raw, asynchronous, bouncing buttons is synchronised
//               (2 FF), debounced (DEBOUNCE_CYCLES stable cycles) and
//               rising-edge detected into a per-direction pending bit. A
//               fixed-priority arbiter (N > S > E > W) grants at most one
//               pending direction per clock and emits it as a registered,
//               one-cycle move pulse.
// Parameters  : DEBOUNCE_CYCLES  stable cycles to accept a level (2..65535)
//               REPEAT_CYCLES    auto-repeat period (>= 2), auto-repeat only
// Macro       : DIR_AUTOREPEAT_EN  when defined, a held button re-arms its
//               pending bit every REPEAT_CYCLES cycles.
// Ports       : clk                        system clock, rising edge
//               reset                      async active-low reset
//               btn_n, btn_s, btn_e, btn_w raw button levels, active-high
//               n, s, e, w                 registered move pulses, one-hot
// Revision    : 1.0  initial release
// ============================================================================
module dir_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    input  logic btn_s,
    input  logic btn_e,
    input  logic btn_w,
    output logic n,
    output logic s,
    output logic e,
    output logic w
);

    localparam int c_NUM_DIR = 4;
    localparam int c_DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_DB_W-1:0] c_DB_MAX = c_DB_W'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time parameter range checks.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("dir_input_conditioner: DEBOUNCE_CYCLES out of range 2..65535");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("dir_input_conditioner: REPEAT_CYCLES must be at least 2");
    end

    // Bit order used throughout: [0]=N, [1]=S, [2]=E, [3]=W.
    logic [c_NUM_DIR-1:0] w_btn;
    logic [c_NUM_DIR-1:0] w_press;   // stable 0->1 on this edge
    logic [c_NUM_DIR-1:0] w_rearm;   // auto-repeat request on this edge
    logic [c_NUM_DIR-1:0] w_grant;
    logic [c_NUM_DIR-1:0] pending_q, pending_d;
    logic [c_NUM_DIR-1:0] out_q, out_d;

    assign w_btn = {btn_w, btn_e, btn_s, btn_n};

    // ------------------------------------------------------------------
    // Per-button synchroniser, debouncer and press detector
    // ------------------------------------------------------------------
    for (genvar i = 0; i < c_NUM_DIR; i++) begin : g_dir
        logic              sync1_q;
        logic              sync2_q;
        logic              stable_q, stable_d;
        logic [c_DB_W-1:0] cnt_q, cnt_d;

        always_comb begin
            stable_d = stable_q;
            cnt_d    = cnt_q;
            if (sync2_q == stable_q) begin
                // Any excursion that ends early lands here and restarts the count.
                cnt_d = '0;
            end else if (cnt_q == c_DB_MAX) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + c_DB_W'(1);
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                stable_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                sync1_q  <= w_btn[i];
                sync2_q  <= sync1_q;
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
            end
        end

        assign w_press[i] = stable_d & ~stable_q;

`ifdef DIR_AUTOREPEAT_EN
        localparam int c_RPT_W = $clog2(REPEAT_CYCLES);
        localparam logic [c_RPT_W-1:0] c_RPT_MAX = c_RPT_W'(REPEAT_CYCLES - 1);

        logic [c_RPT_W-1:0] rpt_q, rpt_d;

        always_comb begin
            rpt_d = rpt_q;
            if (!stable_q || w_press[i]) begin
                rpt_d = '0;
            end else if (rpt_q == c_RPT_MAX) begin
                rpt_d = '0;
            end else begin
                rpt_d = rpt_q + c_RPT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rpt_q <= '0;
            end else begin
                rpt_q <= rpt_d;
            end
        end

        assign w_rearm[i] = stable_q & ~w_press[i] & (rpt_q == c_RPT_MAX);
`else
        assign w_rearm[i] = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // Fixed-priority arbiter: N > S > E > W, one grant per clock
    // ------------------------------------------------------------------
    always_comb begin
        w_grant = '0;
        if (pending_q[0]) begin
            w_grant = 4'b0001;
        end else if (pending_q[1]) begin
            w_grant = 4'b0010;
        end else if (pending_q[2]) begin
            w_grant = 4'b0100;
        end else if (pending_q[3]) begin
            w_grant = 4'b1000;
        end
    end

    // New presses are ORed in after the grant clear so that a press landing
    // on the same edge as its own grant is not lost.
    always_comb begin
        pending_d = (pending_q & ~w_grant) | w_press | w_rearm;
        out_d     = w_grant;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            out_q     <= '0;
        end else begin
            pending_q <= pending_d;
            out_q     <= out_d;
        end
    end

    assign n = out_q[0];
    assign s = out_q[1];
    assign e = out_q[2];
    assign w = out_q[3];

endmodule
`default_nettype wire

// File: tb/tb_dir_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_dir_input_conditioner
// Description : Directed self-checking bench for dir_input_conditioner with
//               DEBOUNCE_CYCLES=4, REPEAT_CYCLES=64. Inputs change on the
//               falling edge; step k means "just after rising edge k counted
//               from the first edge that samples the new input level".
//               Outputs are compared every step as {w,e,s,n}.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dir_input_conditioner;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic btn_n = 1'b0;
    logic btn_s = 1'b0;
    logic btn_e = 1'b0;
    logic btn_w = 1'b0;
    logic n, s, e, w;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dir_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_n),
        .btn_s (btn_s),
        .btn_e (btn_e),
        .btn_w (btn_w),
        .n     (n),
        .s     (s),
        .e     (e),
        .w     (w)
    );

    function automatic logic [3:0] outs();
        return {w, e, s, n};
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got {w,e,s,n}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs ncyc steps; p_x is the step at which output x pulses (0 = never).
    task automatic run_window(input string tag, input int ncyc,
                              input int p_n, input int p_s, input int p_e, input int p_w);
        logic [3:0] exp;
        for (int k = 1; k <= ncyc; k++) begin
            step();
            exp = {(k == p_w), (k == p_e), (k == p_s), (k == p_n)};
            check($sformatf("%s@%0d", tag, k), outs(), exp);
        end
    endtask

    // Called on a falling edge; leaves reset released on a falling edge.
    task automatic apply_reset(input int ncyc);
        reset = 1'b0;
        #1;
        check("rst_async", outs(), 4'b0000);
        @(negedge clk);
        for (int k = 1; k <= ncyc; k++) begin
            step();
            check($sformatf("rst_hold@%0d", k), outs(), 4'b0000);
        end
        reset = 1'b1;
    endtask

    task automatic release_all();
        btn_n = 1'b0;
        btn_s = 1'b0;
        btn_e = 1'b0;
        btn_w = 1'b0;
    endtask

    initial begin
        logic [3:0] exp;

        @(negedge clk);
        apply_reset(2);

        // Single press on N.
        btn_n = 1'b1;
        run_window("single", 20, 7, 0, 0, 0);
        btn_n = 1'b0;
        run_window("single_rel", 10, 0, 0, 0, 0);

        // Bounce on E: 3 high, 2 low, then held.
        apply_reset(1);
        btn_e = 1'b1;
        run_window("bounce_a", 3, 0, 0, 0, 0);
        btn_e = 1'b0;
        run_window("bounce_b", 2, 0, 0, 0, 0);
        btn_e = 1'b1;
        run_window("bounce_c", 15, 0, 0, 7, 0);
        release_all();

        // Simultaneous N, E, W: drained in priority order.
        apply_reset(1);
        btn_n = 1'b1;
        btn_e = 1'b1;
        btn_w = 1'b1;
        run_window("simul", 15, 7, 0, 8, 9);
        release_all();

        // 3-cycle glitch on S, then a real press proves the counter restarted.
        apply_reset(1);
        btn_s = 1'b1;
        run_window("glitch_hi", 3, 0, 0, 0, 0);
        btn_s = 1'b0;
        run_window("glitch_lo", 12, 0, 0, 0, 0);
        btn_s = 1'b1;
        run_window("glitch_re", 12, 0, 7, 0, 0);
        release_all();

        // Reset mid-debounce with N held across it.
        apply_reset(1);
        btn_n = 1'b1;
        run_window("rmid_pre", 3, 0, 0, 0, 0);
        apply_reset(2);
        run_window("rmid_post", 12, 7, 0, 0, 0);
        release_all();

        // Reset while an output is high; held N and S re-detected afterwards.
        apply_reset(1);
        btn_n = 1'b1;
        btn_s = 1'b1;
        run_window("rout_pre", 7, 7, 0, 0, 0);
        apply_reset(2);
        run_window("rout_post", 12, 7, 8, 0, 0);
        release_all();

        // W held for 300 cycles.
        apply_reset(1);
        btn_w = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            step();
`ifdef DIR_AUTOREPEAT_EN
            exp = {(k >= 7 && ((k - 7) % 64) == 0), 3'b000};
`else
            exp = {(k == 7), 3'b000};
`endif
            check($sformatf("hold@%0d", k), outs(), exp);
        end
        btn_w = 1'b0;
        run_window("hold_rel", 80, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
